pc_return_stack: RTL and testbench
==================================

Name: pc_return_stack

Overview:
- Call/return controller that drives the program counter's load interface (DIN / PC_LD).
- On CALL, pushes the return address (current PC + 1) onto an internal LIFO and loads the call target into the PC.
- On RET, pops the top entry and loads it into the PC.
- Sits between the control unit (CALL/RET strobes, target from instruction) and the program counter.

Parameters:
- ADDR_W, 10, PC / stack entry width.
- DEPTH, 16, number of stack entries (power of 2, >= 2).

Ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  synchronous reset, active-low (0 = reset on CLK edge).
- CALL  in  1  push request, sampled when READY=1.
- RET  in  1  pop request, sampled when READY=1.
- CALL_TARGET  in  ADDR_W  jump address for CALL.
- PC_COUNT  in  ADDR_W  current PC value.
- PC_DIN  out  ADDR_W  address to load into PC.
- PC_LD  out  1  one-cycle load strobe to PC.
- READY  out  1  block accepts a request this cycle.
- FULL  out  1  stack holds DEPTH entries.
- EMPTY  out  1  stack holds 0 entries.
- LEVEL  out  $clog2(DEPTH)+1  current entry count.
- FAULT  out  1  sticky overflow/underflow/conflict error.

Behaviour:
- All outputs are registered.
- Reset (RST=0 at edge): state IDLE, LEVEL=0, EMPTY=1, FULL=0, PC_DIN=0, PC_LD=0, READY=1, FAULT=0. Stack RAM contents are don't-care.
- FSM states: IDLE, LOAD, FAULTED.
- IDLE, READY=1. Requests sampled at the edge:
  - CALL=1, RET=0, not FULL: mem[LEVEL] <= ret_addr; LEVEL+1; PC_DIN <= CALL_TARGET; PC_LD <= 1; go to LOAD.
  - RET=1, CALL=0, not EMPTY: PC_DIN <= mem[LEVEL-1]; LEVEL-1; PC_LD <= 1; go to LOAD.
  - CALL with FULL, RET with EMPTY, or CALL=RET=1: no push/pop; PC_LD stays 0; FAULT <= 1; go to FAULTED.
  - Neither request: stay in IDLE.
- ret_addr = PC_COUNT + 1, modulo PC rule: if PC_COUNT = all-ones (0x3FF), ret_addr = 1, never 0.
- LOAD: PC_LD=1 for exactly this one cycle; READY=0; requests are ignored (not queued); next state IDLE with PC_LD=0.
- Latency: request edge -> PC_LD/PC_DIN valid the next cycle -> PC updates on the following edge. Maximum request rate is one per 2 cycles.
- FAULTED: READY=0, PC_LD=0, FAULT=1. LEVEL and memory are frozen. Only reset exits this state.
- FULL = (LEVEL == DEPTH); EMPTY = (LEVEL == 0). Both update in the same cycle as LEVEL.
- Reset during LOAD: PC_LD is forced to 0 at that edge and the push/pop already committed is discarded (LEVEL=0).
- PC_DIN holds its last value when PC_LD=0.

Optional Feature:
- Macro: RET_STACK_CIRCULAR_EN.
- Defined:
  - CALL while FULL overwrites the oldest entry; stack acts as a circular buffer with separate top/base pointers.
  - LEVEL saturates at DEPTH; FULL stays 1; no fault; PC_LD is issued normally.
  - Underflow and CALL+RET conflict still fault.
- Not defined: CALL while FULL faults as described in Behaviour.

Test Plan:
- Reset then idle: RST=0 for 2 cycles, then RST=1 -> LEVEL=0, EMPTY=1, READY=1, PC_LD=0, FAULT=0.
- Single call/return: PC_COUNT=0x010, CALL, CALL_TARGET=0x200 -> next cycle PC_LD=1, PC_DIN=0x200, LEVEL=1. Then RET -> PC_LD=1, PC_DIN=0x011, LEVEL=0, EMPTY=1.
- Wrap rule: PC_COUNT=0x3FF, CALL, target 0x050 -> later RET gives PC_DIN=0x001.
- Nesting to full (DEPTH=16): 16 CALLs with PC_COUNT = 0..15 -> FULL=1. 16 RETs return 16,15,...,1 in LIFO order, then EMPTY=1.
- Faults (macro off):
  - 17th CALL -> FAULT=1, READY=0, no PC_LD, LEVEL=16 stays.
  - Separately, RET when EMPTY -> FAULT=1.
  - Separately, CALL=RET=1 -> FAULT=1.
  - In each case, RST=0 clears the fault.
- Busy/reset corner: CALL accepted, then CALL asserted in LOAD -> ignored, LEVEL=1. Reset asserted during LOAD -> PC_LD=0, LEVEL=0 after the edge. With RET_STACK_CIRCULAR_EN, 17th CALL -> no fault, and 16 RETs return the newest 16 addresses.

Source files
------------

// File: rtl/pc_return_stack.sv
// Call/return stack driving the program counter load port (PC_DIN / PC_LD).
// Define RET_STACK_CIRCULAR_EN to let CALL on a full stack overwrite the oldest entry.
module pc_return_stack #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       CALL,
  input  logic                       RET,
  input  logic [ADDR_W-1:0]          CALL_TARGET,
  input  logic [ADDR_W-1:0]          PC_COUNT,
  output logic [ADDR_W-1:0]          PC_DIN,
  output logic                       PC_LD,
  output logic                       READY,
  output logic                       FULL,
  output logic                       EMPTY,
  output logic [$clog2(DEPTH):0]     LEVEL,
  output logic                       FAULT
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_FAULTED = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [PTR_W-1:0]    top_q, top_d;
  logic [ADDR_W-1:0]   pc_din_q, pc_din_d;
  logic                pc_ld_q, pc_ld_d;
  logic                ready_q, ready_d;
  logic                full_q, full_d;
  logic                empty_q, empty_d;
  logic                fault_q, fault_d;

  logic [ADDR_W-1:0]   mem [DEPTH];
  logic                push_c;
  logic [ADDR_W-1:0]   ret_addr_c;

  // Return address skips 0: an all-ones PC returns to 1.
  assign ret_addr_c = (&PC_COUNT) ? ADDR_W'(1) : PC_COUNT + ADDR_W'(1);

  // Next-state logic; top_q is the next write slot, independent of level_q so
  // the circular variant can wrap while level saturates.
  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    top_d    = top_q;
    pc_din_d = pc_din_q;
    pc_ld_d  = 1'b0;
    fault_d  = fault_q;
    push_c   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (CALL && RET) begin
          fault_d = 1'b1;
          state_d = S_FAULTED;
        end else if (CALL) begin
`ifdef RET_STACK_CIRCULAR_EN
          push_c   = 1'b1;
          top_d    = top_q + PTR_W'(1);
          level_d  = full_q ? level_q : level_q + LVL_W'(1);
          pc_din_d = CALL_TARGET;
          pc_ld_d  = 1'b1;
          state_d  = S_LOAD;
`else
          if (full_q) begin
            fault_d = 1'b1;
            state_d = S_FAULTED;
          end else begin
            push_c   = 1'b1;
            top_d    = top_q + PTR_W'(1);
            level_d  = level_q + LVL_W'(1);
            pc_din_d = CALL_TARGET;
            pc_ld_d  = 1'b1;
            state_d  = S_LOAD;
          end
`endif
        end else if (RET) begin
          if (empty_q) begin
            fault_d = 1'b1;
            state_d = S_FAULTED;
          end else begin
            top_d    = top_q - PTR_W'(1);
            level_d  = level_q - LVL_W'(1);
            pc_din_d = mem[top_q - PTR_W'(1)];
            pc_ld_d  = 1'b1;
            state_d  = S_LOAD;
          end
        end
      end
      S_LOAD:    state_d = S_IDLE;
      S_FAULTED: state_d = S_FAULTED;
      default:   state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
    full_d  = (level_d == LVL_W'(DEPTH));
    empty_d = (level_d == LVL_W'(0));
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      level_q  <= '0;
      top_q    <= '0;
      pc_din_q <= '0;
      pc_ld_q  <= 1'b0;
      ready_q  <= 1'b1;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      top_q    <= top_d;
      pc_din_q <= pc_din_d;
      pc_ld_q  <= pc_ld_d;
      ready_q  <= ready_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      fault_q  <= fault_d;
    end
  end

  // Stack storage carries no reset; only entries below LEVEL are ever read.
  always_ff @(posedge CLK) begin
    if (RST && push_c) begin
      mem[top_q] <= ret_addr_c;
    end
  end

  assign PC_DIN = pc_din_q;
  assign PC_LD  = pc_ld_q;
  assign READY  = ready_q;
  assign FULL   = full_q;
  assign EMPTY  = empty_q;
  assign LEVEL  = level_q;
  assign FAULT  = fault_q;

endmodule

// File: tb/tb_pc_return_stack.sv
// Bench for pc_return_stack: directed scenarios plus randomized traffic against a queue model.
module tb_pc_return_stack;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned LVL_W  = $clog2(DEPTH) + 1;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              CALL = 1'b0;
  logic              RET = 1'b0;
  logic [ADDR_W-1:0] CALL_TARGET = '0;
  logic [ADDR_W-1:0] PC_COUNT = '0;
  logic [ADDR_W-1:0] PC_DIN;
  logic              PC_LD, READY, FULL, EMPTY, FAULT;
  logic [LVL_W-1:0]  LEVEL;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the stack is a queue, newest at the back.
  int unsigned stk[$];
  bit          m_busy, m_faulted, m_ld;
  int unsigned m_din;

  pc_return_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .CALL(CALL), .RET(RET),
    .CALL_TARGET(CALL_TARGET), .PC_COUNT(PC_COUNT),
    .PC_DIN(PC_DIN), .PC_LD(PC_LD), .READY(READY), .FULL(FULL),
    .EMPTY(EMPTY), .LEVEL(LEVEL), .FAULT(FAULT)
  );

  always #5 CLK = ~CLK;

  task automatic model_edge();
    int unsigned ra;
    m_ld = 1'b0;
    if (!RST) begin
      stk.delete();
      m_busy = 0; m_faulted = 0; m_din = 0;
    end else if (m_faulted) begin
    end else if (m_busy) begin
      m_busy = 0;
    end else if (CALL && RET) begin
      m_faulted = 1;
    end else if (CALL) begin
      ra = (int'(PC_COUNT) + 1) % (1 << ADDR_W);
      if (ra == 0) ra = 1;
      if (stk.size() == DEPTH) begin
`ifdef RET_STACK_CIRCULAR_EN
        void'(stk.pop_front());
        stk.push_back(ra);
        m_din = CALL_TARGET; m_ld = 1; m_busy = 1;
`else
        m_faulted = 1;
`endif
      end else begin
        stk.push_back(ra);
        m_din = CALL_TARGET; m_ld = 1; m_busy = 1;
      end
    end else if (RET) begin
      if (stk.size() == 0) m_faulted = 1;
      else begin
        m_din = stk.pop_back(); m_ld = 1; m_busy = 1;
      end
    end
  endtask

  // Apply inputs for one edge, advance the model, settle past the edge.
  task automatic cyc(input bit c, input bit r, input int unsigned tgt, input int unsigned pc);
    CALL = c; RET = r;
    CALL_TARGET = ADDR_W'(tgt); PC_COUNT = ADDR_W'(pc);
    @(posedge CLK);
    model_edge();
    #1;
    CALL = 1'b0; RET = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    cyc(0, 0, 0, 0);
    RST = 1'b1;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    RST = 1'b1;
    cyc(0, 0, 0, 0);
    n_vec++;
    if ({LEVEL, EMPTY, FULL, READY, PC_LD, FAULT, PC_DIN} !== {LVL_W'(0), 5'b10100, ADDR_W'(0)}) begin
      n_err++;
      $display("FAIL reset: lvl=%0d e=%b f=%b rdy=%b ld=%b flt=%b din=%h", LEVEL, EMPTY, FULL, READY, PC_LD, FAULT, PC_DIN);
    end
  endtask

  task automatic test_single_call_ret();
    cyc(1, 0, 'h200, 'h010);
    n_vec++;
    if ({PC_LD, PC_DIN, LEVEL, READY} !== {1'b1, ADDR_W'('h200), LVL_W'(1), 1'b0}) begin
      n_err++;
      $display("FAIL call: ld=%b din=%h lvl=%0d rdy=%b, want 1 200 1 0", PC_LD, PC_DIN, LEVEL, READY);
    end
    cyc(0, 0, 0, 0);
    n_vec++;
    if ({PC_LD, READY, PC_DIN} !== {2'b01, ADDR_W'('h200)}) begin
      n_err++;
      $display("FAIL call_hold: ld=%b rdy=%b din=%h, want 0 1 200", PC_LD, READY, PC_DIN);
    end
    cyc(0, 1, 0, 'h200);
    n_vec++;
    if ({PC_LD, PC_DIN, LEVEL, EMPTY} !== {1'b1, ADDR_W'('h011), LVL_W'(0), 1'b1}) begin
      n_err++;
      $display("FAIL ret: ld=%b din=%h lvl=%0d e=%b, want 1 011 0 1", PC_LD, PC_DIN, LEVEL, EMPTY);
    end
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_wrap();
    cyc(1, 0, 'h050, 'h3FF);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 'h050);
    n_vec++;
    if ({PC_LD, PC_DIN} !== {1'b1, ADDR_W'('h001)}) begin
      n_err++;
      $display("FAIL wrap: ld=%b din=%h, want 1 001", PC_LD, PC_DIN);
    end
    cyc(0, 0, 0, 0);
  endtask

  task automatic fill_stack();
    for (int i = 0; i < int'(DEPTH); i++) begin
      cyc(1, 0, 'h100 + i, i);
      cyc(0, 0, 0, 0);
    end
  endtask

  task automatic test_nesting_full();
    fill_stack();
    n_vec++;
    if ({FULL, EMPTY, LEVEL} !== {2'b10, LVL_W'(DEPTH)}) begin
      n_err++;
      $display("FAIL full: f=%b e=%b lvl=%0d", FULL, EMPTY, LEVEL);
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      cyc(0, 1, 0, 0);
      n_vec++;
      if ({PC_LD, PC_DIN} !== {1'b1, ADDR_W'(DEPTH - i)}) begin
        n_err++;
        $display("FAIL lifo[%0d]: ld=%b din=%0d want %0d", i, PC_LD, PC_DIN, DEPTH - i);
      end
      cyc(0, 0, 0, 0);
    end
    n_vec++;
    if ({EMPTY, LEVEL} !== {1'b1, LVL_W'(0)}) begin
      n_err++;
      $display("FAIL drained: e=%b lvl=%0d", EMPTY, LEVEL);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    fill_stack();
    cyc(1, 0, 'h3AA, DEPTH);
`ifdef RET_STACK_CIRCULAR_EN
    n_vec++;
    if ({FAULT, PC_LD, FULL, LEVEL} !== {3'b011, LVL_W'(DEPTH)}) begin
      n_err++;
      $display("FAIL circ_push: flt=%b ld=%b f=%b lvl=%0d", FAULT, PC_LD, FULL, LEVEL);
    end
    cyc(0, 0, 0, 0);
    for (int i = 0; i < int'(DEPTH); i++) begin
      cyc(0, 1, 0, 0);
      n_vec++;
      if (PC_DIN !== ADDR_W'(DEPTH + 1 - i)) begin
        n_err++;
        $display("FAIL circ_pop[%0d]: din=%0d want %0d", i, PC_DIN, DEPTH + 1 - i);
      end
      cyc(0, 0, 0, 0);
    end
`else
    n_vec++;
    if ({FAULT, READY, PC_LD, LEVEL} !== {3'b100, LVL_W'(DEPTH)}) begin
      n_err++;
      $display("FAIL overflow: flt=%b rdy=%b ld=%b lvl=%0d", FAULT, READY, PC_LD, LEVEL);
    end
    cyc(0, 1, 0, 0);
    n_vec++;
    if ({FAULT, READY, PC_LD, LEVEL} !== {3'b100, LVL_W'(DEPTH)}) begin
      n_err++;
      $display("FAIL fault_frozen: flt=%b rdy=%b ld=%b lvl=%0d", FAULT, READY, PC_LD, LEVEL);
    end
`endif
    do_reset();
    cyc(0, 0, 0, 0);
    n_vec++;
    if ({FAULT, READY, LEVEL} !== {2'b01, LVL_W'(0)}) begin
      n_err++;
      $display("FAIL overflow_clear: flt=%b rdy=%b lvl=%0d", FAULT, READY, LEVEL);
    end
  endtask

  task automatic test_underflow_conflict();
    cyc(0, 1, 0, 0);
    n_vec++;
    if ({FAULT, READY, PC_LD} !== 3'b100) begin
      n_err++;
      $display("FAIL underflow: flt=%b rdy=%b ld=%b", FAULT, READY, PC_LD);
    end
    do_reset();
    cyc(1, 0, 'h123, 'h020);
    cyc(0, 0, 0, 0);
    cyc(1, 1, 'h155, 'h030);
    n_vec++;
    if ({FAULT, READY, PC_LD, LEVEL, PC_DIN} !== {3'b100, LVL_W'(1), ADDR_W'('h123)}) begin
      n_err++;
      $display("FAIL conflict: flt=%b rdy=%b ld=%b lvl=%0d din=%h", FAULT, READY, PC_LD, LEVEL, PC_DIN);
    end
    do_reset();
    n_vec++;
    if ({FAULT, READY, EMPTY} !== 3'b011) begin
      n_err++;
      $display("FAIL conflict_clear: flt=%b rdy=%b e=%b", FAULT, READY, EMPTY);
    end
  endtask

  task automatic test_busy_and_reset_in_load();
    cyc(1, 0, 'h0AA, 'h005);
    cyc(1, 0, 'h0BB, 'h006);
    n_vec++;
    if ({LEVEL, PC_LD, READY, PC_DIN} !== {LVL_W'(1), 2'b01, ADDR_W'('h0AA)}) begin
      n_err++;
      $display("FAIL busy_ignore: lvl=%0d ld=%b rdy=%b din=%h", LEVEL, PC_LD, READY, PC_DIN);
    end
    cyc(1, 0, 'h0CC, 'h007);
    RST = 1'b0;
    cyc(0, 0, 0, 0);
    n_vec++;
    if ({PC_LD, LEVEL, EMPTY} !== {1'b0, LVL_W'(0), 1'b1}) begin
      n_err++;
      $display("FAIL reset_in_load: ld=%b lvl=%0d e=%b", PC_LD, LEVEL, EMPTY);
    end
    RST = 1'b1;
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_random();
    int unsigned sel, pc;
    bit c, r;
    for (int i = 0; i < 3000; i++) begin
      sel = $urandom_range(99);
      c = (sel < 45) || (sel == 99);
      r = (sel >= 45 && sel < 80) || (sel == 99);
      pc = ($urandom_range(7) == 0) ? 'h3FF : $urandom_range('h3FF);
      RST = !((m_faulted && $urandom_range(3) == 0) || $urandom_range(299) == 0);
      cyc(c, r, $urandom_range('h3FF), pc);
      n_vec++;
      if ({PC_LD, READY, FULL, EMPTY, FAULT, LEVEL, PC_DIN} !==
          {m_ld, !m_busy && !m_faulted, stk.size() == DEPTH, stk.size() == 0,
           m_faulted, LVL_W'(stk.size()), ADDR_W'(m_din)}) begin
        n_err++;
        $display("FAIL random[%0d]: ld=%b rdy=%b f=%b e=%b flt=%b lvl=%0d din=%h want ld=%b flt=%b lvl=%0d din=%h",
                 i, PC_LD, READY, FULL, EMPTY, FAULT, LEVEL, PC_DIN, m_ld, m_faulted, stk.size(), m_din);
      end
    end
    RST = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_call_ret();
    test_wrap();
    test_nesting_full();
    test_overflow();
    test_underflow_conflict();
    test_busy_and_reset_in_load();
    do_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
